// File: rtl/up_counter.sv
// up_counter: modulo up-counter with terminal-count tick.
//
// Counts 0..MAX in steps of 1 while enable is high, wraps to 0 after MAX,
// and holds while enable is low. Reset is synchronous and active-high.
//
// Parameters:
//   COUNT_BITS - width of the count register (>= 1)
//   MAX        - terminal count, 1 <= MAX <= 2^COUNT_BITS - 1
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   synchronous active-high reset, clears count
//   enable   in   count-advance qualifier
//   count    out  registered counter value
//   max_tick out  terminal-count indicator
//
// Build option:
//   UP_COUNTER_GATED_TICK_EN - when defined, max_tick = (count == MAX) && enable,
//   so the tick fires only in the cycle where the wrap actually happens.
//   When undefined, max_tick = (count == MAX) regardless of enable.

module up_counter #(
  parameter int unsigned COUNT_BITS = 3,
  parameter int unsigned MAX        = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [COUNT_BITS-1:0] count,
  output logic                  max_tick
);

  // Reject parameter sets where MAX is zero or does not fit in the register.
  // The shift form avoids overflowing 2**COUNT_BITS for wide counters.
  if ((COUNT_BITS < 1) || (MAX < 1) || ((MAX >> COUNT_BITS) != 0)) begin : g_bad_params
    $error("up_counter: illegal parameters COUNT_BITS=%0d MAX=%0d", COUNT_BITS, MAX);
  end

  localparam logic [COUNT_BITS-1:0] MaxCount = COUNT_BITS'(MAX);
  localparam logic [COUNT_BITS-1:0] OneCount = COUNT_BITS'(1);

  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  at_max;

  assign at_max = (count_q == MaxCount);

  // An out-of-range value (only reachable by deposit) is never equal to MAX,
  // so it keeps incrementing and wraps naturally at 2^COUNT_BITS.
  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = at_max ? '0 : count_q + OneCount;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef UP_COUNTER_GATED_TICK_EN
  assign max_tick = at_max && enable;
`else
  assign max_tick = at_max;
`endif

endmodule

// File: tb/tb_up_counter.sv
module tb_up_counter;

  typedef struct {
    logic       reset;
    logic       enable;
    logic [2:0] exp_count;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] count;
  logic       max_tick;

  logic       reset7 = 1'b1;
  logic       enable7 = 1'b0;
  logic [2:0] count7;
  logic       max_tick7;

  int n_vec = 0;
  int n_err = 0;

  vec_t vecs[$];

`ifdef UP_COUNTER_GATED_TICK_EN
  localparam bit Gated = 1'b1;
`else
  localparam bit Gated = 1'b0;
`endif

  always #5 clk = ~clk;

  up_counter #(.COUNT_BITS(3), .MAX(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .count    (count),
    .max_tick (max_tick)
  );

  up_counter #(.COUNT_BITS(3), .MAX(7)) dut7 (
    .clk      (clk),
    .reset    (reset7),
    .enable   (enable7),
    .count    (count7),
    .max_tick (max_tick7)
  );

  // Expected tick for a counter with terminal value tc given count and enable.
  function automatic logic exp_tick(input logic [2:0] c, input logic [2:0] tc, input logic e);
    return (c == tc) && (e || !Gated);
  endfunction

  task automatic add(input logic r, input logic e, input logic [2:0] c);
    vec_t v;
    v.reset = r;
    v.enable = e;
    v.exp_count = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  initial begin
    int ticks;

    // 1. Reset with enable high.
    add(1'b1, 1'b1, 3'd0);
    add(1'b1, 1'b1, 3'd0);
    // 2. Free run for 12 edges.
    for (int i = 1; i <= 12; i++) add(1'b0, 1'b1, 3'(i % 6));
    // 3. Count to 3, hold 4 edges, resume.
    for (int i = 1; i <= 3; i++) add(1'b0, 1'b1, 3'(i));
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 3'd3);
    add(1'b0, 1'b1, 3'd4);
    add(1'b0, 1'b1, 3'd5);
    add(1'b0, 1'b1, 3'd0);
    // 4. Count to 5, hold at terminal, then wrap.
    for (int i = 1; i <= 5; i++) add(1'b0, 1'b1, 3'(i));
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 3'd5);
    add(1'b0, 1'b1, 3'd0);
    // 5. Reset mid-count at 4, then release.
    for (int i = 1; i <= 4; i++) add(1'b0, 1'b1, 3'(i));
    add(1'b1, 1'b1, 3'd0);
    add(1'b0, 1'b1, 3'd1);

    @(negedge clk);
    foreach (vecs[i]) begin
      reset = vecs[i].reset;
      enable = vecs[i].enable;
      @(posedge clk);
      #1;
      check($sformatf("count[%0d]", i), count, vecs[i].exp_count);
      check($sformatf("max_tick[%0d]", i), {2'b00, max_tick},
            {2'b00, exp_tick(vecs[i].exp_count, 3'd5, enable)});
    end

    // Period check: exactly 2 ticks in 12 cycles of free running from 0.
    reset = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (max_tick) ticks++;
    end
    check("tick_period_count", 3'(ticks), 3'd2);

    // 6. MAX = 2^COUNT_BITS - 1: MAX wrap and natural wrap coincide.
    enable = 1'b0;
    enable7 = 1'b1;
    @(posedge clk);
    #1;
    check("max7_reset_count", count7, 3'd0);
    check("max7_reset_tick", {2'b00, max_tick7}, 3'd0);
    reset7 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("max7_count[%0d]", i), count7, 3'(i % 8));
      check($sformatf("max7_tick[%0d]", i), {2'b00, max_tick7},
            {2'b00, exp_tick(3'(i % 8), 3'd7, enable7)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
